des3_result_fifo: RTL
=====================

// Module: des3_result_fifo
// PURPOSE
//  Result buffer downstream of the des3 core. Captures each 64-bit desOut block when out_valid rises.
//  Queues results in a small FIFO so software can read several blocks without losing any.
//  Presents the head entry, fill level, sticky error flags and a level interrupt to the Wishbone register file.
//  Sits between the des3 core (out_valid/desOut) and the des3_top read mux / int_o.
// PARAMETERS
//  DEPTH       4   number of 64-bit entries; must be a power of two, >= 2
//  AW          2   pointer width, log2(DEPTH)
//  IRQ_THRESH  1   irq_o asserts when count >= IRQ_THRESH; legal range 1..DEPTH
// PORTS
//  wb_clk_i    in   1       clock; all state updates on rising edge
//  wb_rst_i    in   1       asynchronous, active-low reset
//  res_valid_i in   1       des3 out_valid (level); each rising edge is one new result
//  res_data_i  in   64      des3 desOut; sampled in the same cycle the rising edge is detected
//  pop_i       in   1       one-cycle pulse from the register file; removes the head entry
//  clr_i       in   1       one-cycle pulse; flushes the FIFO and clears sticky flags
//  irq_en_i    in   1       interrupt enable
//  head_o      out  64      current head entry; 64'h0 when empty
//  count_o     out  AW+1    number of valid entries, 0..DEPTH
//  empty_o     out  1       count_o == 0
//  full_o      out  1       count_o == DEPTH
//  ovf_o       out  1       sticky: a result was dropped because the FIFO was full
//  udf_o       out  1       sticky: pop_i arrived while the FIFO was empty
//  irq_o       out  1       registered interrupt, level
// BEHAVIOUR
//  Reset (async, wb_rst_i=0): wr_ptr=rd_ptr=0, count_o=0, empty_o=1, full_o=0, ovf_o=0, udf_o=0, irq_o=0, head_o=0.
//   Edge-detect register vr resets to 1. If res_valid_i is held high through reset, that stale result is not
//   captured; capture resumes after res_valid_i drops low and rises again.
//   Memory contents are not reset; head_o is forced to 0 while empty.
//  Edge detect: vr <= res_valid_i every cycle; push_req = res_valid_i & ~vr.
//  Per-cycle priority, evaluated in this order:
//   1. clr_i=1: wr_ptr=rd_ptr=count=0, ovf=udf=0. push_req and pop_i in the same cycle are discarded.
//   2. pop = pop_i & (count!=0). If pop_i=1 and count=0, set udf (no pointer change).
//   3. push = push_req & (count!=DEPTH | pop).
//      If push_req=1, count=DEPTH and no pop, set ovf and drop the data.
//   4. push writes mem[wr_ptr]<=res_data_i and increments wr_ptr. pop increments rd_ptr.
//      count += push - pop. Simultaneous push+pop leaves count unchanged, including when full.
//  Pointers are AW bits and wrap naturally DEPTH-1 -> 0. count is AW+1 bits and never exceeds DEPTH.
//  head_o = (count==0) ? 0 : mem[rd_ptr] (combinational from registered state).
//   A push into an empty FIFO is visible on head_o the cycle after the edge: 1-cycle capture latency.
//   After pop, head_o shows the next entry on the following cycle.
//  empty_o and full_o are decoded from the registered count.
//  irq_o <= irq_en_i & (count_next >= IRQ_THRESH) & ~clr_i, where count_next is the post-update count.
//   irq_o therefore rises in the same cycle count_o reaches the threshold.
//   Dropping irq_en_i deasserts irq_o on the next edge.
//  Sticky flags clear only on clr_i or reset. Setting a flag and clr_i in the same cycle: clr_i wins.
//  A result arriving while res_valid_i stays high is one push; a continuous high level never pushes twice.
// TESTING
//  1. Reset with res_valid_i=1 -> after release, no push; count_o=0. Toggle 0->1 with data
//     64'h0123456789ABCDEF -> next cycle count_o=1, head_o=64'h0123456789ABCDEF.
//  2. Five rising edges with data 1..5, DEPTH=4, no pops -> count_o=4, full_o=1, ovf_o=1.
//     Pops then return 1,2,3,4 in order; empty_o=1 afterwards.
//  3. FIFO full (1..4), push 5 and pop_i in the same cycle -> count_o stays 4, ovf_o=0.
//     Head sequence is 2,3,4,5 (pointer wrap exercised).
//  4. pop_i while empty -> udf_o=1, count_o=0, head_o=0. Next, clr_i with a push edge in the same cycle
//     -> udf_o=0, count_o=0, no entry written.
//  5. irq_en_i=1, IRQ_THRESH=2: first push -> irq_o=0; second push -> irq_o=1 in the same cycle count_o=2.
//     pop -> irq_o=0; irq_en_i=0 with count_o=2 -> irq_o=0.
//  6. Async reset asserted mid-stream at count_o=3 -> all outputs at reset values immediately, without a clock edge.

Source files
------------

// File: rtl/des3_result_fifo.sv
// des3_result_fifo: result buffer behind the des3 core.
// Captures one 64-bit desOut block per rising edge of out_valid and queues the blocks.
// Presents the head entry, fill level, sticky overflow/underflow flags and a level
// interrupt to the Wishbone register file.
//
// Handshake: there is no backpressure toward the core. A rising edge of res_valid_i
// is a push request that must be taken or dropped in that same cycle; a dropped
// request sets ovf_o. pop_i is a one-cycle request from the register file that
// retires the head entry. A pop_i that arrives while the FIFO is empty sets udf_o.
// clr_i overrides both push and pop in the cycle it is high.
module des3_result_fifo #(
  parameter int DEPTH      = 4,
  parameter int AW         = 2,
  parameter int IRQ_THRESH = 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          res_valid_i,
  input  logic [63:0]   res_data_i,
  input  logic          pop_i,
  input  logic          clr_i,
  input  logic          irq_en_i,
  output logic [63:0]   head_o,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          ovf_o,
  output logic          udf_o,
  output logic          irq_o
);

  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH_C = (AW+1)'(IRQ_THRESH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          vr;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          set_ovf;
  logic          set_udf;
  logic          ovf;
  logic          udf;
  logic          irq;

  // Per-cycle decision: clear beats pop, pop beats the full check for push.
  always_comb begin
    push_req   = res_valid_i & ~vr;
    push       = 1'b0;
    pop        = 1'b0;
    set_ovf    = 1'b0;
    set_udf    = 1'b0;
    count_next = '0;
    if (!clr_i) begin
      pop        = pop_i & (count != '0);
      set_udf    = pop_i & (count == '0);
      push       = push_req & ((count != DEPTH_C) | pop);
      set_ovf    = push_req & (count == DEPTH_C) & ~pop;
      count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Pointers, fill level, sticky flags, edge detector and registered interrupt.
  // vr resets high so that a result still held valid through reset is not captured.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      irq    <= 1'b0;
      vr     <= 1'b1;
    end else begin
      vr    <= res_valid_i;
      count <= count_next;
      irq   <= irq_en_i & (count_next >= THRESH_C) & ~clr_i;
      if (clr_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf    <= 1'b0;
        udf    <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (set_ovf) ovf <= 1'b1;
        if (set_udf) udf <= 1'b1;
      end
    end
  end

  // Storage array; no reset, since head_o is masked while the FIFO is empty.
  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= res_data_i;
  end

  assign head_o  = (count == '0) ? 64'h0 : mem[rd_ptr];
  assign count_o = count;
  assign empty_o = (count == '0);
  assign full_o  = (count == DEPTH_C);
  assign ovf_o   = ovf;
  assign udf_o   = udf;
  assign irq_o   = irq;

endmodule
